// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared types for the RAM-port arbiter: RAM status encoding, arbiter
//   state, and the {is_data, core} grant word.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic is_data;
    logic core;
  } arb_grant_t;

endpackage

// File: rtl/mem_bus_arbiter_prio_sel.sv
// arb_prio_sel
//   Combinational 4-way priority picker. Data requests always beat
//   instruction requests; within a class the core named by ptr goes first.
//   Ports:
//     dreq  - per-core data request (read or write)
//     ireq  - per-core instruction request
//     ptr   - round-robin pointer (core that is favoured in each class)
//     grant - winning {is_data, core}
//     valid - 1 when any request is present
module arb_prio_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] dreq,
  input  logic [1:0] ireq,
  input  logic       ptr,
  output arb_grant_t grant,
  output logic       valid
);

  logic np;
  assign np = ~ptr;

  // NOTE: every output gets a default before the if-chain so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    if (dreq[ptr]) begin
      grant = '{is_data: 1'b1, core: ptr};
      valid = 1'b1;
    end else if (dreq[np]) begin
      grant = '{is_data: 1'b1, core: np};
      valid = 1'b1;
    end else if (ireq[ptr]) begin
      grant = '{is_data: 1'b0, core: ptr};
      valid = 1'b1;
    end else if (ireq[np]) begin
      grant = '{is_data: 1'b0, core: np};
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single RAM port between icache0/1 and dcache0/1. In IDLE the
//   winner is latched into the grant register; in GRANT the RAM is driven
//   from that requester until ramstate reports ACCESS (completion, one-cycle
//   wait pulse) or the requester withdraws (silent abort).
//   Ports:
//     CLK, RST              - clock, synchronous active-high reset
//     iREN/iaddr            - per-core instruction read request/address
//     iwait/iload           - per-core instruction wait / read data
//     dREN/dWEN/daddr/dstore- per-core data request, address, write data
//     dwait/dload           - per-core data wait / read data
//     ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate - RAM master port
//   Build option: define MEM_ARB_RR_EN for a round-robin pointer between
//   cores; otherwise the pointer is tied to 0 (fixed priority).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int CORES = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CORES-1:0]    iREN,
  input  logic [CORES*AW-1:0] iaddr,
  output logic [CORES-1:0]    iwait,
  output logic [CORES*DW-1:0] iload,
  input  logic [CORES-1:0]    dREN,
  input  logic [CORES-1:0]    dWEN,
  input  logic [CORES*AW-1:0] daddr,
  input  logic [CORES*DW-1:0] dstore,
  output logic [CORES-1:0]    dwait,
  output logic [CORES*DW-1:0] dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [AW-1:0]       ramaddr,
  output logic [DW-1:0]       ramstore,
  input  logic [DW-1:0]       ramload,
  input  logic [1:0]          ramstate
);

  arb_state_t state, next_state;
  arb_grant_t grant, next_grant, sel_grant;
  logic       sel_valid;
  logic       ptr;
  logic [1:0] dreq;
  logic       live, g_write, done;
  logic [AW-1:0] g_iaddr, g_daddr;
  logic [DW-1:0] g_dstore;

  assign dreq = dREN | dWEN;

  arb_prio_sel u_prio_sel (
    .dreq  (dreq),
    .ireq  (iREN),
    .ptr   (ptr),
    .grant (sel_grant),
    .valid (sel_valid)
  );

  // Granted requester's live request and operands.
  assign g_iaddr  = grant.core ? iaddr[2*AW-1:AW]   : iaddr[AW-1:0];
  assign g_daddr  = grant.core ? daddr[2*AW-1:AW]   : daddr[AW-1:0];
  assign g_dstore = grant.core ? dstore[2*DW-1:DW]  : dstore[DW-1:0];
  assign live     = grant.is_data ? dreq[grant.core] : iREN[grant.core];
  // A data requester raising both strobes is treated as a write.
  assign g_write  = grant.is_data & dWEN[grant.core];
  assign done     = (state == GRANT) && live && (ramstate == ACCESS);

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge CLK) begin
    if (RST)       ptr <= 1'b0;
    else if (done) ptr <= ~ptr;
  end
`else
  assign ptr = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= next_state;
      grant <= next_grant;
    end
  end

  always_comb begin
    next_state = state;
    next_grant = grant;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    dwait      = '1;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          next_grant = sel_grant;
          next_state = GRANT;
        end
      end
      GRANT: begin
        ramaddr = grant.is_data ? g_daddr : g_iaddr;
        if (!live) begin
          // Requester withdrew: abandon the transfer without a wait pulse.
          next_state = IDLE;
        end else begin
          ramWEN   = g_write;
          ramREN   = ~g_write;
          ramstore = g_write ? g_dstore : '0;
          // BUSY/FREE/ERROR simply hold here, re-issuing the same access.
          if (ramstate == ACCESS) begin
            next_state = IDLE;
            if (grant.is_data) begin
              dwait[grant.core] = 1'b0;
              if (grant.core) dload[2*DW-1:DW] = ramload;
              else            dload[DW-1:0]    = ramload;
            end else begin
              iwait[grant.core] = 1'b0;
              if (grant.core) iload[2*DW-1:DW] = ramload;
              else            iload[DW-1:0]    = ramload;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a requester-level model of the arbiter (owner id + pointer).
//   Requester ids: 0 = dcache0, 1 = dcache1, 2 = icache0, 3 = icache1.
module tb_mem_bus_arbiter;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1,
                         RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  logic        CLK, RST;
  logic [1:0]  iREN, dREN, dWEN, iwait, dwait, ramstate;
  logic [63:0] iaddr, daddr, dstore, iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;

  mem_bus_arbiter #(.CORES(2), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which requester owns the RAM (-1 = none) and the pointer.
  int m_owner = -1;
  bit m_ptr   = 1'b0;
  int m_done  = -1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit line(input int id);
    if (id < 2) return dREN[id] | dWEN[id];
    return iREN[id-2];
  endfunction

  // Serve order: dcache[p], dcache[~p], icache[p], icache[~p].
  function automatic int pick();
    int order[4];
    order = m_ptr ? '{1, 0, 3, 2} : '{0, 1, 2, 3};
    foreach (order[k]) if (line(order[k])) return order[k];
    return -1;
  endfunction

  task automatic set_line(input int id, input bit v);
    if (id < 2) begin
      dREN[id] = v;
      if (!v) dWEN[id] = 1'b0;
    end else begin
      iREN[id-2] = v;
    end
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    logic [1:0]  e_iw, e_dw;
    logic [63:0] e_il, e_dl;
    logic        e_ren, e_wen, wr;
    logic [31:0] e_addr, e_store;
    #1;
    e_iw = 2'b11; e_dw = 2'b11; e_il = '0; e_dl = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    m_done = -1;
    if (m_owner >= 0) begin
      e_addr = (m_owner < 2) ? daddr[m_owner*32 +: 32]
                             : iaddr[(m_owner-2)*32 +: 32];
      if (line(m_owner)) begin
        wr      = (m_owner < 2) && dWEN[m_owner];
        e_wen   = wr;
        e_ren   = !wr;
        e_store = wr ? dstore[m_owner*32 +: 32] : 32'h0;
        if (ramstate == RS_ACCESS) begin
          m_done = m_owner;
          if (m_owner < 2) begin
            e_dw[m_owner] = 1'b0;
            e_dl[m_owner*32 +: 32] = ramload;
          end else begin
            e_iw[m_owner-2] = 1'b0;
            e_il[(m_owner-2)*32 +: 32] = ramload;
          end
        end
      end
    end
    check("iwait", iwait, e_iw);
    check("dwait", dwait, e_dw);
    check("iload", iload, e_il);
    check("dload", dload, e_dl);
    check("ramREN", ramREN, e_ren);
    check("ramWEN", ramWEN, e_wen);
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
  endtask

  // Clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      m_owner = -1;
      m_ptr   = 1'b0;
    end else if (m_owner < 0) begin
      m_owner = pick();
    end else if (!line(m_owner)) begin
      m_owner = -1;
    end else if (ramstate == RS_ACCESS) begin
      m_owner = -1;
`ifdef MEM_ARB_RR_EN
      m_ptr = ~m_ptr;
`endif
    end
    @(negedge CLK);
  endtask

  initial begin
    int served[$];
    int clr;
    int exp_order[4];
    bit clear_next[4];

    // ---- reset held with a pending data request
    RST = 1'b1; iREN = '0; dREN = 2'b01; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      check("rst_dwait", dwait, 2'b11);
      check("rst_iwait", iwait, 2'b11);
      check("rst_ramREN", ramREN, 1'b0);
      tick();
    end

    // ---- single instruction read, two BUSY cycles then ACCESS
    RST = 1'b0; dREN = '0; iREN = 2'b01; iaddr[31:0] = 32'h100;
    ramstate = RS_BUSY;
    settle(); tick();
    settle(); check("rd_addr_c1", ramaddr, 32'h100);
    check("rd_wait_c1", iwait[0], 1'b1); tick();
    settle(); check("rd_wait_c2", iwait[0], 1'b1); tick();
    ramstate = RS_ACCESS; ramload = 32'hDEADBEEF;
    settle(); check("rd_wait_c3", iwait[0], 1'b0);
    check("rd_load_c3", iload[31:0], 32'hDEADBEEF); tick();
    iREN = '0; ramstate = RS_FREE;
    settle(); check("rd_wait_c4", iwait, 2'b11);
    check("rd_load_c4", iload, 64'h0); tick();

    // ---- all four at once, RAM always ready
    iREN = 2'b11; dREN = 2'b11; ramstate = RS_ACCESS; ramload = 32'h5A5A0000;
    iaddr = {32'h3000, 32'h2000}; daddr = {32'h1000, 32'h0800};
    for (int c = 0; c < 20 && served.size() < 4; c++) begin
      settle();
      clr = -1;
      for (int id = 0; id < 4; id++)
        if (((id < 2) ? dwait[id] : iwait[id-2]) == 1'b0) begin
          served.push_back(id);
          clr = id;
        end
      tick();
      if (clr >= 0) set_line(clr, 1'b0);
    end
    exp_order = '{0, 1, 2, 3};
    check("all4_count", served.size(), 4);
    for (int k = 0; k < 4 && k < served.size(); k++)
      check($sformatf("all4_order%0d", k), served[k], exp_order[k]);
    settle(); check("all4_idle_wait", {iwait, dwait}, 4'hF); tick();

    // ---- simultaneous read+write on dcache1 is a write
    dREN = 2'b10; dWEN = 2'b10; daddr[63:32] = 32'h40; dstore[63:32] = 32'h1234;
    ramstate = RS_BUSY;
    settle(); tick();
    settle(); check("rw_wen", ramWEN, 1'b1); check("rw_ren", ramREN, 1'b0);
    check("rw_store", ramstore, 32'h1234); check("rw_addr", ramaddr, 32'h40);
    tick();
    ramstate = RS_ACCESS;
    settle(); check("rw_dwait", dwait, 2'b01); tick();
    dREN = '0; dWEN = '0; ramstate = RS_FREE;

    // ---- ERROR x3 then ACCESS on dcache0 read
    dREN = 2'b01; daddr[31:0] = 32'h80; ramload = 32'hCAFE0001;
    settle(); tick();
    ramstate = RS_ERROR;
    for (int c = 0; c < 3; c++) begin
      settle(); check("err_ren", ramREN, 1'b1);
      check("err_addr", ramaddr, 32'h80); check("err_dwait", dwait, 2'b11);
      tick();
    end
    ramstate = RS_ACCESS;
    settle(); check("err_done", dwait, 2'b10);
    check("err_load", dload[31:0], 32'hCAFE0001); tick();
    dREN = '0; ramstate = RS_FREE;

    // ---- abort: dcache0 withdraws mid-GRANT
    dREN = 2'b01; ramstate = RS_BUSY;
    settle(); tick();
    settle(); check("ab_ren", ramREN, 1'b1); tick();
    dREN = '0;
    settle(); check("ab_drop_ren", ramREN, 1'b0);
    check("ab_drop_wait", dwait, 2'b11); tick();
    ramstate = RS_ACCESS;
    settle(); check("ab_idle_addr", ramaddr, 32'h0);
    check("ab_idle_wait", dwait, 2'b11); tick();

    // ---- reset mid-GRANT
    dREN = 2'b01; ramstate = RS_BUSY;
    settle(); tick();
    settle(); check("rg_ren", ramREN, 1'b1);
    RST = 1'b1; tick();
    settle(); check("rg_ren_after", ramREN, 1'b0);
    check("rg_wen_after", ramWEN, 1'b0); tick();
    RST = 1'b0; dREN = '0; ramstate = RS_FREE;
    settle(); tick();

    // ---- randomized traffic
    clear_next = '{default: 1'b0};
    for (int c = 0; c < 2000; c++) begin
      for (int id = 0; id < 4; id++) begin
        if (clear_next[id]) begin
          set_line(id, 1'b0);
          clear_next[id] = 1'b0;
        end else if (!line(id)) begin
          if ($urandom_range(0, 2) == 0) begin
            if (id < 2) begin
              daddr[id*32 +: 32]  = $urandom;
              dstore[id*32 +: 32] = $urandom;
              case ($urandom_range(0, 2))
                0: begin dREN[id] = 1'b1; dWEN[id] = 1'b0; end
                1: begin dREN[id] = 1'b0; dWEN[id] = 1'b1; end
                default: begin dREN[id] = 1'b1; dWEN[id] = 1'b1; end
              endcase
            end else begin
              iaddr[(id-2)*32 +: 32] = $urandom;
              iREN[id-2] = 1'b1;
            end
          end
        end else if ($urandom_range(0, 59) == 0) begin
          set_line(id, 1'b0);
        end
      end
      case ($urandom_range(0, 9))
        0, 1:       ramstate = RS_BUSY;
        2:          ramstate = RS_FREE;
        3:          ramstate = RS_ERROR;
        default:    ramstate = RS_ACCESS;
      endcase
      ramload = $urandom;
      RST = ($urandom_range(0, 199) == 0);
      settle();
      if (m_done >= 0) clear_next[m_done] = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
